// File: rtl/nw_job_controller.sv
// nw_job_controller: runs one Needleman-Wunsch alignment job at a time on a
// systolic grid. It accepts a request, pulses the grid clear, waits for the
// grid's completion flag (or gives up at a timeout), and then holds the result
// on the response port until the consumer takes it.
module nw_job_controller #(
  parameter int LENGTH     = 10,
  parameter int CWIDTH     = 2,
  parameter int SWIDTH     = 16,
  parameter int TAGW       = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1023,
  parameter int CNTW       = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  // request port
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [LENGTH*CWIDTH-1:0]   req_s1,
  input  logic [LENGTH*CWIDTH-1:0]   req_s2,
  input  logic [TAGW-1:0]            req_tag,
  // grid side
  output logic                       grid_reset,
  output logic [LENGTH*CWIDTH-1:0]   grid_s1,
  output logic [LENGTH*CWIDTH-1:0]   grid_s2,
  input  logic [SWIDTH-1:0]          grid_score,
  input  logic                       grid_valid,
  // response port
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SWIDTH-1:0]          rsp_score,
  output logic [TAGW-1:0]            rsp_tag,
  output logic                       rsp_timeout,
  output logic [CNTW-1:0]            rsp_cycles,
  // status
  output logic                       busy,
  output logic [15:0]                jobs_done
);

  localparam int SW = LENGTH * CWIDTH;
  // Clear-pulse counter only has to hold RST_CYCLES-1.
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]   RST_LOAD  = RW'(RST_CYCLES - 1);
  localparam logic [CNTW-1:0] TIMEOUT_C = CNTW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q,       state_d;
  logic [RW-1:0]     rst_cnt_q,     rst_cnt_d;
  logic [CNTW-1:0]   cnt_q,         cnt_d;
  logic [SW-1:0]     s1_q,          s1_d;
  logic [SW-1:0]     s2_q,          s2_d;
  logic [TAGW-1:0]   tag_q,         tag_d;
  logic [SWIDTH-1:0] rsp_score_q,   rsp_score_d;
  logic [TAGW-1:0]   rsp_tag_q,     rsp_tag_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNTW-1:0]   rsp_cycles_q,  rsp_cycles_d;
  logic [15:0]       jobs_q,        jobs_d;

  // RUN cycles consumed including the current one.
  logic [CNTW-1:0]   run_cnt;
  assign run_cnt = cnt_q + 1'b1;

  // Next-state and datapath update for the job sequencer.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned; that is what keeps this block free of latches.
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cnt_d         = cnt_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    tag_d         = tag_q;
    rsp_score_d   = rsp_score_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_cycles_d  = rsp_cycles_q;
    jobs_d        = jobs_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          s1_d      = req_s1;
          s2_d      = req_s2;
          tag_d     = req_tag;
          rst_cnt_d = RST_LOAD;
          state_d   = S_CLEAR;
        end
      end

      S_CLEAR: begin
        // The entry cycle counts as the first clear cycle.
        if (rst_cnt_q == '0) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end

      S_RUN: begin
        cnt_d = run_cnt;
        // The first RUN cycle ignores grid_valid: the flag may still be left
        // over from the previous job before the clear has propagated.
        if (grid_valid && (cnt_q != '0)) begin
          rsp_score_d   = grid_score;
          rsp_cycles_d  = run_cnt;
          rsp_timeout_d = 1'b0;
          rsp_tag_d     = tag_q;
          state_d       = S_RESP;
        end else if (run_cnt == TIMEOUT_C) begin
          rsp_score_d   = '0;
          rsp_cycles_d  = TIMEOUT_C;
          rsp_timeout_d = 1'b1;
          rsp_tag_d     = tag_q;
          state_d       = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          jobs_d  = jobs_q + 16'd1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight job.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cnt_q         <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      tag_q         <= '0;
      rsp_score_q   <= '0;
      rsp_tag_q     <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_cycles_q  <= '0;
      jobs_q        <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cnt_q         <= cnt_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      tag_q         <= tag_d;
      rsp_score_q   <= rsp_score_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_cycles_q  <= rsp_cycles_d;
      jobs_q        <= jobs_d;
    end
  end

  // Handshake and grid controls decode straight from the state register.
  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  // Grid is held clear everywhere except while it is computing.
  assign grid_reset  = (state_q != S_RUN);

  assign grid_s1     = s1_q;
  assign grid_s2     = s2_q;
  assign rsp_score   = rsp_score_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_cycles  = rsp_cycles_q;
  assign jobs_done   = jobs_q;

endmodule

// File: tb/tb_nw_job_controller.sv
// Testbench for nw_job_controller. A behavioural grid computes real NW scores
// (match +1, mismatch -1, gap -1) and raises its flag a chosen number of RUN
// cycles in; a timeline-based model predicts every controller output.
module tb_nw_job_controller;

  localparam int LEN  = 4;
  localparam int CW   = 2;
  localparam int SWD  = 16;
  localparam int TW   = 8;
  localparam int RST  = 2;
  localparam int TOUT = 20;
  localparam int CNW  = 10;
  localparam int SW   = LEN * CW;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [SW-1:0]   req_s1, req_s2;
  logic [TW-1:0]   req_tag;
  logic            grid_reset;
  logic [SW-1:0]   grid_s1, grid_s2;
  logic [SWD-1:0]  grid_score;
  logic            grid_valid;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [SWD-1:0]  rsp_score;
  logic [TW-1:0]   rsp_tag;
  logic            rsp_timeout;
  logic [CNW-1:0]  rsp_cycles;
  logic            busy;
  logic [15:0]     jobs_done;

  nw_job_controller #(
    .LENGTH(LEN), .CWIDTH(CW), .SWIDTH(SWD), .TAGW(TW),
    .RST_CYCLES(RST), .TIMEOUT(TOUT), .CNTW(CNW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s1(req_s1), .req_s2(req_s2), .req_tag(req_tag),
    .grid_reset(grid_reset), .grid_s1(grid_s1), .grid_s2(grid_s2),
    .grid_score(grid_score), .grid_valid(grid_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_score(rsp_score), .rsp_tag(rsp_tag),
    .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Needleman-Wunsch global alignment score by dynamic programming.
  function automatic int nw(input logic [SW-1:0] a, input logic [SW-1:0] b);
    int h [0:LEN][0:LEN];
    int d, u, l;
    for (int i = 0; i <= LEN; i++) h[i][0] = -i;
    for (int j = 0; j <= LEN; j++) h[0][j] = -j;
    for (int i = 1; i <= LEN; i++) begin
      for (int j = 1; j <= LEN; j++) begin
        d = h[i-1][j-1] + ((a[(i-1)*CW +: CW] == b[(j-1)*CW +: CW]) ? 1 : -1);
        u = h[i-1][j] - 1;
        l = h[i][j-1] - 1;
        h[i][j] = d;
        if (u > h[i][j]) h[i][j] = u;
        if (l > h[i][j]) h[i][j] = l;
      end
    end
    return h[LEN][LEN];
  endfunction

  // ---------------- behavioural grid ----------------
  // grid_lat: RUN cycle on which the completion flag rises (<0 = never).
  // stale:    flag also high on the first RUN cycle (left over from before).
  int gcnt     = 0;
  int grid_lat = 5;
  bit stale    = 1'b0;

  initial begin
    grid_valid = 1'b0;
    grid_score = '0;
  end

  always @(posedge clk) begin
    #1;
    if (grid_reset) gcnt = 0;
    else            gcnt++;
    grid_valid = ((grid_lat > 0) && (gcnt >= grid_lat)) || (stale && (gcnt == 1));
    grid_score = SWD'(nw(grid_s1, grid_s2));
  end

  // ---------------- reference model + per-cycle compare ----------------
  // A job is described by its age (cycles since the accepting edge): ages
  // 1..RST are the clear pulse, RST+1..RST+m_cyc are RUN, later is RESP.
  bit             m_known = 1'b0;
  bit             m_busy  = 1'b0;
  int             m_age   = 0;
  int             m_cyc   = 0;
  bit             m_to    = 1'b0;
  logic [SWD-1:0] m_score = '0;
  logic [TW-1:0]  m_tag   = '0;
  logic [SW-1:0]  m_s1    = '0;
  logic [SW-1:0]  m_s2    = '0;
  logic [15:0]    m_jobs  = '0;

  always @(negedge clk) begin
    bit exp_run, exp_rv;
    int eff;
    if (m_known) begin
      exp_run = m_busy && (m_age > RST) && (m_age <= RST + m_cyc);
      exp_rv  = m_busy && (m_age > RST + m_cyc);
      check("req_ready",  32'(req_ready),  32'(!m_busy));
      check("busy",       32'(busy),       32'(m_busy));
      check("grid_reset", 32'(grid_reset), 32'(!exp_run));
      check("rsp_valid",  32'(rsp_valid),  32'(exp_rv));
      check("grid_s1",    32'(grid_s1),    32'(m_s1));
      check("grid_s2",    32'(grid_s2),    32'(m_s2));
      check("jobs_done",  32'(jobs_done),  32'(m_jobs));
      if (exp_rv) begin
        check("rsp_score",   32'(rsp_score),   32'(m_score));
        check("rsp_tag",     32'(rsp_tag),     32'(m_tag));
        check("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
        check("rsp_cycles",  32'(rsp_cycles),  32'(m_cyc));
      end
    end
    // advance the model across the coming edge
    if (reset) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_jobs  = '0;
      m_s1    = '0;
      m_s2    = '0;
    end else if (m_known) begin
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1'b1;
          m_age  = 1;
          m_s1   = req_s1;
          m_s2   = req_s2;
          m_tag  = req_tag;
          // first RUN cycle is blind to the flag, so the earliest hit is 2
          eff = (grid_lat <= 0) ? TOUT + 1 : ((grid_lat < 2) ? 2 : grid_lat);
          if (eff <= TOUT) begin
            m_cyc = eff; m_to = 1'b0; m_score = SWD'(nw(req_s1, req_s2));
          end else begin
            m_cyc = TOUT; m_to = 1'b1; m_score = '0;
          end
        end
      end else if ((m_age > RST + m_cyc) && rsp_ready) begin
        m_busy = 1'b0;
        m_jobs = m_jobs + 16'd1;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [SW-1:0] s1, input logic [SW-1:0] s2, input logic [TW-1:0] tag);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_s1 = s1; req_s2 = s2; req_tag = tag;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin seen = 1'b1; break; end
    end
    check("req_accepted", 32'(seen), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    check("rsp_arrived", 32'(seen), 32'd1);
  endtask

  // advance past the handshake into the following IDLE cycle
  task automatic next_idle();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_s1 = '0; req_s2 = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_grid_reset", 32'(grid_reset), 32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_score",  32'(rsp_score),  32'd0);
    check("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
    check("rst_jobs_done",  32'(jobs_done),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Job 1: identical strings, clear pulse exactly two cycles.
    grid_lat = 5;
    send(8'h1B, 8'h1B, 8'h5A);
    @(negedge clk); check("j1_clear1", 32'(grid_reset), 32'd1);
    @(negedge clk); check("j1_clear2", 32'(grid_reset), 32'd1);
    @(negedge clk); check("j1_run1",   32'(grid_reset), 32'd0);
    wait_rsp(100);
    check("j1_score",   32'(rsp_score),   32'd4);
    check("j1_tag",     32'(rsp_tag),     32'h5A);
    check("j1_timeout", 32'(rsp_timeout), 32'd0);
    check("j1_cycles",  32'(rsp_cycles),  32'd5);
    next_idle();
    check("j1_jobs", 32'(jobs_done), 32'd1);

    // Job 2: all mismatches gives a negative score.
    send(8'h00, 8'hFF, 8'h11);
    wait_rsp(100);
    check("j2_score",   32'(rsp_score),   32'h0000FFFC);
    check("j2_timeout", 32'(rsp_timeout), 32'd0);
    next_idle();

    // Job 3: grid never finishes -> timeout.
    grid_lat = -1;
    send(8'h1B, 8'h1B, 8'h33);
    wait_rsp(100);
    check("j3_timeout", 32'(rsp_timeout), 32'd1);
    check("j3_score",   32'(rsp_score),   32'd0);
    check("j3_cycles",  32'(rsp_cycles),  32'd20);
    next_idle();

    // Job 4: normal job after a timeout.
    grid_lat = 4;
    send(8'hE4, 8'hE4, 8'h44);
    wait_rsp(100);
    check("j4_timeout", 32'(rsp_timeout), 32'd0);
    check("j4_cycles",  32'(rsp_cycles),  32'd4);
    check("j4_score",   32'(rsp_score),   32'd4);
    next_idle();
    check("j4_jobs", 32'(jobs_done), 32'd4);

    // Job 5: 50 cycles of back-pressure.
    grid_lat = 5;
    rsp_ready = 1'b0;
    send(8'h1B, 8'h1E, 8'h77);
    wait_rsp(100);
    repeat (49) @(negedge clk);
    check("bp_rsp_valid",  32'(rsp_valid),  32'd1);
    check("bp_req_ready",  32'(req_ready),  32'd0);
    check("bp_grid_reset", 32'(grid_reset), 32'd1);
    check("bp_tag",        32'(rsp_tag),    32'h77);
    check("bp_cycles",     32'(rsp_cycles), 32'd5);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_jobs_before", 32'(jobs_done), 32'd4);
    next_idle();
    check("bp_jobs_after",  32'(jobs_done), 32'd5);
    check("bp_idle_valid",  32'(rsp_valid), 32'd0);

    // Job 6: stale flag on first RUN cycle, real completion on cycle 3.
    stale = 1'b1; grid_lat = 3;
    send(8'h55, 8'h55, 8'h66);
    wait_rsp(100);
    check("j6_cycles", 32'(rsp_cycles), 32'd3);
    check("j6_score",  32'(rsp_score),  32'd4);
    next_idle();
    stale = 1'b0;

    // Job 7: reset during RUN drops the job.
    grid_lat = 5;
    send(8'h1B, 8'h00, 8'h99);
    @(posedge clk); #1;                 // CLEAR cycle 2
    @(posedge clk); #1;                 // RUN cycle 1
    @(posedge clk); #1; reset = 1'b1;   // RUN cycle 2
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("rr_req_ready",  32'(req_ready),  32'd1);
    check("rr_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rr_jobs_done",  32'(jobs_done),  32'd0);
    check("rr_grid_reset", 32'(grid_reset), 32'd1);
    check("rr_busy",       32'(busy),       32'd0);
    check("rr_grid_s1",    32'(grid_s1),    32'd0);

    // Job 8: recovery after reset.
    send(8'h1B, 8'hFF, 8'hA5);
    wait_rsp(100);
    check("j8_tag", 32'(rsp_tag), 32'hA5);
    next_idle();
    check("j8_jobs", 32'(jobs_done), 32'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/nw_job_controller.md
Name: nw_job_controller

Overview:
- Sequences alignment jobs through one Needleman-Wunsch systolic grid.
- Accepts string pairs over a valid/ready request port and latches them onto the grid inputs.
- Clears the grid with a reset pulse, then waits for the grid's completion flag, with a timeout.
- Returns score, tag, cycle count and timeout status over a valid/ready response port. Only one job is in flight at a time.

Parameters:
- LENGTH, 10, characters per string; grid is LENGTH x LENGTH.
- CWIDTH, 2, bits per character.
- SWIDTH, 16, bits per signed score.
- TAGW, 8, job tag width.
- RST_CYCLES, 2, cycles grid_reset is held high per job (minimum 1).
- TIMEOUT, 1023, maximum RUN cycles before the job is aborted.
- CNTW, 10, cycle counter width; must satisfy 2^CNTW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  job request present
- req_ready  out  1  controller can accept a job
- req_s1  in  LENGTH*CWIDTH  string 1
- req_s2  in  LENGTH*CWIDTH  string 2
- req_tag  in  TAGW  job identifier
- grid_reset  out  1  clear pulse to grid
- grid_s1  out  LENGTH*CWIDTH  latched string 1 to grid
- grid_s2  out  LENGTH*CWIDTH  latched string 2 to grid
- grid_score  in  SWIDTH  grid final score
- grid_valid  in  1  grid completion flag (level)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_score  out  SWIDTH  captured score (0 on timeout)
- rsp_tag  out  TAGW  tag of completed job
- rsp_timeout  out  1  job aborted by timeout
- rsp_cycles  out  CNTW  RUN cycles consumed
- busy  out  1  high in any state except IDLE
- jobs_done  out  16  count of responses handed off, wraps at 2^16

Behaviour:
- Reset values, applied on a clk edge with reset=1:
  - state=IDLE; all outputs 0.
  - Exception: req_ready=1 and grid_reset=1 (grid held clear).
  - grid_s1/grid_s2/rsp_* cleared to 0; jobs_done=0.
  - Reset overrides everything, including a mid-job or pending response; the in-flight job is dropped silently.
- States:
  - IDLE:
    - req_ready=1; grid_reset=1.
    - On req_valid&req_ready: latch req_s1/s2/tag into grid_s1/s2/tag register, load the RST_CYCLES counter, go to CLEAR.
  - CLEAR:
    - req_ready=0; grid_reset=1 for exactly RST_CYCLES cycles, counting the entry cycle.
    - Then go to RUN with cycle counter=0.
  - RUN:
    - grid_reset=0; the cycle counter increments every cycle.
    - grid_valid is masked in the first RUN cycle, to guard against stale flags.
    - From the second cycle on, grid_valid=1 captures grid_score and the counter into rsp_score/rsp_cycles, sets rsp_timeout=0, goes to RESP.
    - If the counter reaches TIMEOUT with no valid: rsp_score=0, rsp_cycles=TIMEOUT, rsp_timeout=1, go to RESP.
    - If valid and timeout occur in the same cycle, valid wins.
  - RESP:
    - rsp_valid=1; grid_reset=1, so the grid is parked clear and the strings are held.
    - All rsp_* fields are stable until handshake.
    - On rsp_valid&rsp_ready: jobs_done++, rsp_valid drops next cycle, go to IDLE.
    - Back-pressure may be unbounded.
- No request is accepted back-to-back with the response handshake; IDLE lasts at least 1 cycle.
- grid_s1/grid_s2 change only on request acceptance.
- Latency: request accept to RUN entry = RST_CYCLES+1 cycles. Grid completion to rsp_valid = 1 cycle.
- Score is treated as signed; it is passed through unmodified, with no saturation.

Test Plan:
- LENGTH=4, CWIDTH=2, s1=s2=0x1B, tag=0x5A, rsp_ready=1:
  - grid_reset high exactly 2 cycles after accept.
  - rsp_score=+4, rsp_tag=0x5A, rsp_timeout=0, jobs_done=1.
- LENGTH=4, s1=0x00, s2=0xFF (all mismatch) -> rsp_score=-4 (0xFFFC), rsp_timeout=0.
- Grid model never asserts grid_valid, TIMEOUT=20:
  - rsp_valid after 20 RUN cycles; rsp_timeout=1, rsp_score=0, rsp_cycles=20.
  - A subsequent job completes normally.
- rsp_ready held 0 for 50 cycles:
  - rsp_* stable, req_ready=0, grid_reset=1 throughout.
  - Handshake on cycle 51 -> IDLE, jobs_done increments once.
- Stale grid_valid=1 on the first RUN cycle is ignored; a valid on the 3rd RUN cycle gives rsp_cycles=3.
- reset asserted during RUN -> next cycle: IDLE, req_ready=1, rsp_valid=0, jobs_done=0, grid_reset=1.
